// File: rtl/gsim_residual_check.sv
// gsim_residual_check
// Checks convergence of the Gauss-Seidel solver. It recomputes the residual
// r_i = b_i - (A x)_i for the fixed 16x16 banded system
// (20 on the diagonal, -13 at i+-1, +6 at i+-2, -1 at i+-3, with no wrap-around)
// and reports the largest |r_i| and the row where it occurs.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high
//   in_en    b word valid; this is the same strobe the solver receives
//   b_in     signed integer b word, rows 0..15 in order
//   x_valid  solver out_valid
//   x_in     signed 16.16 solver x word, rows 0..15 in order
//   busy     high while in LOAD_X, CALC or DRAIN
//   done     result valid; held until the next run or reset
//   pass     max_err <= TOL; only meaningful when done=1
//   max_err  unsigned max |r_i| in 16.16 LSBs
//   err_idx  lowest row index that reaches max_err
module gsim_residual_check #(
  parameter int          N   = 16,
  parameter logic [37:0] TOL = 38'd4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_en,
  input  logic signed [15:0] b_in,
  input  logic               x_valid,
  input  logic signed [31:0] x_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [37:0]        max_err,
  output logic [3:0]         err_idx
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_B = 3'd1,
    S_LOAD_X = 3'd2,
    S_CALC   = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Absolute value. The most negative 38-bit value cannot occur here.
  function automatic logic [37:0] abs38(input logic signed [37:0] v);
    logic signed [37:0] neg;
    neg = -v;
    return v[37] ? neg : v;
  endfunction

  state_t             state_q, state_d;
  logic [3:0]         b_ptr_q, b_ptr_d;
  logic [3:0]         x_ptr_q, x_ptr_d;
  logic [3:0]         k_q, k_d;
  logic [1:0]         dcnt_q, dcnt_d;
  logic signed [15:0] b_q [N];
  logic signed [31:0] x_q [N];

  logic               b_we_s, x_we_s, start_s, finish_s, issue_s, run_s;
  logic [3:0]         b_wa_s;

  logic               v1_q, v2_q;
  logic [3:0]         i1_q, i2_q;
  logic signed [37:0] s_q;
  logic [37:0]        a_q;

  logic               busy_q, done_q, pass_q;
  logic [37:0]        max_err_q;
  logic [3:0]         err_idx_q;

  logic signed [37:0] tap_s [7];
  logic signed [37:0] c0_s, c1_s, c2_s, c3_s, s_row_s;
  logic signed [37:0] b_ext_s, diff_s;

  // Next-state logic, store write enables and pointer updates.
  // An in_en pulse outside LOAD_B always starts a fresh run, with the current word stored as b[0].
  always_comb begin
    state_d  = state_q;
    b_ptr_d  = b_ptr_q;
    x_ptr_d  = x_ptr_q;
    k_d      = k_q;
    dcnt_d   = dcnt_q;
    b_we_s   = 1'b0;
    b_wa_s   = b_ptr_q;
    x_we_s   = 1'b0;
    start_s  = 1'b0;
    finish_s = 1'b0;
    case (state_q)
      S_LOAD_B: begin
        if (in_en) begin
          b_we_s  = 1'b1;
          b_ptr_d = b_ptr_q + 4'd1;
        end else begin
          state_d = S_LOAD_X;
          x_ptr_d = 4'd0;
        end
      end
      S_LOAD_X, S_CALC, S_DRAIN, S_IDLE, S_DONE: begin
        if (in_en) begin
          state_d = S_LOAD_B;
          b_we_s  = 1'b1;
          b_wa_s  = 4'd0;
          b_ptr_d = 4'd1;
          x_ptr_d = 4'd0;
          start_s = 1'b1;
        end else if (state_q == S_LOAD_X) begin
          if (x_valid) begin
            x_we_s  = 1'b1;
            x_ptr_d = x_ptr_q + 4'd1;
            if (x_ptr_q == 4'd15) begin
              state_d = S_CALC;
              k_d     = 4'd0;
            end else begin
              state_d = S_LOAD_X;
            end
          end else begin
            state_d = S_LOAD_X;
          end
        end else if (state_q == S_CALC) begin
          k_d = k_q + 4'd1;
          if (k_q == 4'd15) begin
            state_d = S_DRAIN;
            dcnt_d  = 2'd0;
          end else begin
            state_d = S_CALC;
          end
        end else if (state_q == S_DRAIN) begin
          if (dcnt_q == 2'd2) begin
            state_d  = S_DONE;
            finish_s = 1'b1;
          end else begin
            dcnt_d = dcnt_q + 2'd1;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    issue_s = (state_q == S_CALC) && !in_en;
    run_s   = ((state_q == S_CALC) || (state_q == S_DRAIN)) && !in_en;
  end

  // Stage-1 band product for row k. Taps whose index falls outside 0..15 contribute zero.
  always_comb begin
    for (int j = 0; j < 7; j++) begin : g_tap
      logic [5:0] pos;
      pos = {2'b00, k_q} + 6'(j) - 6'd3;
      if (pos <= 6'd15) begin
        tap_s[j] = {{6{x_q[pos[3:0]][31]}}, x_q[pos[3:0]]};
      end else begin
        tap_s[j] = 38'sd0;
      end
    end
    c0_s    = tap_s[3];
    c1_s    = tap_s[2] + tap_s[4];
    c2_s    = tap_s[1] + tap_s[5];
    c3_s    = tap_s[0] + tap_s[6];
    // 20c0 - 13c1 + 6c2 - c3, built from shifts and adds
    s_row_s = (c0_s <<< 4) + (c0_s <<< 2)
            - ((c1_s <<< 3) + (c1_s <<< 2) + c1_s)
            + ((c2_s <<< 2) + (c2_s <<< 1))
            - c3_s;
    b_ext_s = {{6{b_q[i1_q][15]}}, b_q[i1_q], 16'h0000};
    diff_s  = b_ext_s - s_q;
  end

  // State, pointer and busy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      b_ptr_q <= 4'd0;
      x_ptr_q <= 4'd0;
      k_q     <= 4'd0;
      dcnt_q  <= 2'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      b_ptr_q <= b_ptr_d;
      x_ptr_q <= x_ptr_d;
      k_q     <= k_d;
      dcnt_q  <= dcnt_d;
      busy_q  <= (state_d == S_LOAD_X) || (state_d == S_CALC) || (state_d == S_DRAIN);
    end
  end

  // b and x operand stores.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        b_q[i] <= 16'sd0;
        x_q[i] <= 32'sd0;
      end
    end else begin
      if (b_we_s) b_q[b_wa_s] <= b_in;
      if (x_we_s) x_q[x_ptr_q] <= x_in;
    end
  end

  // Three-stage residual pipeline. An abort flushes the valid bits so that stale rows cannot update the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      i1_q <= 4'd0;
      i2_q <= 4'd0;
      s_q  <= 38'sd0;
      a_q  <= 38'd0;
    end else begin
      v1_q <= issue_s;
      v2_q <= v1_q && run_s;
      if (issue_s) begin
        s_q  <= s_row_s;
        i1_q <= k_q;
      end
      if (v1_q) begin
        a_q  <= abs38(diff_s);
        i2_q <= i1_q;
      end
    end
  end

  // Result registers. A strict compare keeps the lowest index on ties.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      max_err_q <= 38'd0;
      err_idx_q <= 4'd0;
    end else if (start_s) begin
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      max_err_q <= 38'd0;
      err_idx_q <= 4'd0;
    end else if (finish_s) begin
      done_q <= 1'b1;
      pass_q <= (max_err_q <= TOL);
    end else if (v2_q && run_s && (a_q > max_err_q)) begin
      max_err_q <= a_q;
      err_idx_q <= i2_q;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign max_err = max_err_q;
  assign err_idx = err_idx_q;

endmodule

// File: tb/tb_gsim_residual_check.sv
module tb_gsim_residual_check;

  logic               clk = 1'b0;
  logic               reset, in_en, x_valid;
  logic signed [15:0] b_in;
  logic signed [31:0] x_in;
  logic               busy, done, pass;
  logic [37:0]        max_err;
  logic [3:0]         err_idx;
  logic               busy2, done2, pass2;
  logic [37:0]        max_err2;
  logic [3:0]         err_idx2;

  int chk_total = 0;
  int chk_pass  = 0;

  logic signed [15:0] b_vec [16];
  logic signed [31:0] x_vec [16];

  always #5 clk = ~clk;

  gsim_residual_check dut (
    .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in),
    .x_valid(x_valid), .x_in(x_in), .busy(busy), .done(done),
    .pass(pass), .max_err(max_err), .err_idx(err_idx)
  );

  // second instance with the tolerance raised to exactly 1.0
  gsim_residual_check #(.TOL(38'd65536)) dut_tol1 (
    .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in),
    .x_valid(x_valid), .x_in(x_in), .busy(busy2), .done(done2),
    .pass(pass2), .max_err(max_err2), .err_idx(err_idx2)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_total++;
    if (obs === exp) chk_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic set_all(input logic signed [15:0] bv, input logic signed [31:0] xv);
    for (int i = 0; i < 16; i++) begin
      b_vec[i] = bv;
      x_vec[i] = xv;
    end
  endtask

  // Stream b_vec. The trailing in_en=0 cycle moves the DUT to LOAD_X.
  task automatic send_b(input string tag);
    for (int i = 0; i < 16; i++) begin
      in_en = 1'b1;
      b_in  = b_vec[i];
      @(posedge clk); #1;
      if (i == 0) begin
        check_val({tag, ".start_busy"}, 64'(busy), 64'd0);
        check_val({tag, ".start_done"}, 64'(done), 64'd0);
      end
    end
    in_en = 1'b0;
    b_in  = 16'sd0;
    @(posedge clk); #1;
  endtask

  // Stream x_vec, keep x_valid high as the solver does, and check result timing and values.
  task automatic send_x_wait(input string tag, input logic [37:0] emax, input logic [3:0] eidx,
                             input logic epass, input logic epass2);
    for (int i = 0; i < 16; i++) begin
      x_valid = 1'b1;
      x_in    = x_vec[i];
      @(posedge clk); #1;
    end
    x_in = 32'sh7fff0000;
    for (int c = 1; c <= 19; c++) begin
      @(posedge clk); #1;
      if (c == 18) begin
        check_val({tag, ".done_e18"}, 64'(done), 64'd0);
        check_val({tag, ".busy_e18"}, 64'(busy), 64'd1);
      end
    end
    check_val({tag, ".done_e19"}, 64'(done), 64'd1);
    check_val({tag, ".busy_e19"}, 64'(busy), 64'd0);
    check_val({tag, ".max_err"},  64'(max_err), 64'(emax));
    check_val({tag, ".err_idx"},  64'(err_idx), 64'(eidx));
    check_val({tag, ".pass"},     64'(pass), 64'(epass));
    check_val({tag, ".pass_tol1"}, 64'(pass2), 64'(epass2));
    repeat (3) @(posedge clk);
    #1;
    check_val({tag, ".hold_max"},  64'(max_err), 64'(emax));
    check_val({tag, ".hold_done"}, 64'(done), 64'd1);
    x_valid = 1'b0;
    x_in    = 32'sd0;
  endtask

  initial begin
    reset   = 1'b1;
    in_en   = 1'b0;
    x_valid = 1'b0;
    b_in    = 16'sd0;
    x_in    = 32'sd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst.busy",    64'(busy), 64'd0);
    check_val("rst.done",    64'(done), 64'd0);
    check_val("rst.pass",    64'(pass), 64'd0);
    check_val("rst.max_err", 64'(max_err), 64'd0);
    check_val("rst.err_idx", 64'(err_idx), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: all zero
    set_all(16'sd0, 32'sd0);
    send_b("t1");
    send_x_wait("t1", 38'd0, 4'd0, 1'b1, 1'b1);

    // 2: x = 1.0, b chosen to zero every residual, including the truncated edge rows
    set_all(16'sd4, 32'sd65536);
    b_vec[0] = 16'sd12; b_vec[1] = -16'sd1; b_vec[2] = 16'sd5;
    b_vec[13] = 16'sd5; b_vec[14] = -16'sd1; b_vec[15] = 16'sd12;
    send_b("t2");
    send_x_wait("t2", 38'd0, 4'd0, 1'b1, 1'b1);

    // 3: single x in the middle
    set_all(16'sd0, 32'sd0);
    x_vec[5] = 32'sd65536;
    send_b("t3");
    send_x_wait("t3", 38'd1310720, 4'd5, 1'b0, 1'b0);

    // 4a: x[0] only, no wrap
    set_all(16'sd0, 32'sd0);
    x_vec[0] = 32'sd65536;
    send_b("t4a");
    send_x_wait("t4a", 38'd1310720, 4'd0, 1'b0, 1'b0);

    // 4b: tie between rows 0 and 15 keeps row 0
    x_vec[15] = 32'sd65536;
    send_b("t4b");
    send_x_wait("t4b", 38'd1310720, 4'd0, 1'b0, 1'b0);

    // 4c: x[15] only, so the maximum is at row 15
    x_vec[0] = 32'sd0;
    send_b("t4c");
    send_x_wait("t4c", 38'd1310720, 4'd15, 1'b0, 1'b0);

    // 5: b[0]=1, x=0; the 1.0 tolerance boundary is inclusive
    set_all(16'sd0, 32'sd0);
    b_vec[0] = 16'sd1;
    send_b("t5");
    send_x_wait("t5", 38'd65536, 4'd0, 1'b0, 1'b1);

    // 6a: restart in LOAD_X. The new b[0]=0 must replace the old b[0]=5
    set_all(16'sd0, 32'sd0);
    b_vec[0] = 16'sd5;
    send_b("t6a_first");
    for (int i = 0; i < 8; i++) begin
      x_valid = 1'b1;
      x_in    = 32'sd0;
      @(posedge clk); #1;
    end
    x_valid = 1'b0;
    set_all(16'sd0, 32'sd0);
    b_vec[3] = 16'sd2;
    send_b("t6a_restart");
    send_x_wait("t6a", 38'd131072, 4'd3, 1'b0, 1'b0);

    // 6b: reset at CALC cycle 8 while a partial maximum is already recorded
    set_all(16'sd0, 32'sd0);
    x_vec[5] = 32'sd65536;
    send_b("t6b");
    for (int i = 0; i < 16; i++) begin
      x_valid = 1'b1;
      x_in    = x_vec[i];
      @(posedge clk); #1;
    end
    repeat (8) @(posedge clk);
    #1;
    check_val("t6b.calc_done", 64'(done), 64'd0);
    check_val("t6b.calc_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("t6b.rst_busy",    64'(busy), 64'd0);
    check_val("t6b.rst_done",    64'(done), 64'd0);
    check_val("t6b.rst_pass",    64'(pass), 64'd0);
    check_val("t6b.rst_max_err", 64'(max_err), 64'd0);
    check_val("t6b.rst_err_idx", 64'(err_idx), 64'd0);
    reset   = 1'b0;
    x_valid = 1'b0;
    @(posedge clk); #1;

    // 6c: full run after the reset
    send_b("t6c");
    send_x_wait("t6c", 38'd1310720, 4'd5, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
